// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
// Optional build macro for the mux: MUX_SCAN_BLANK_EN (one blanking cycle on channel change).
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  localparam logic MODO_MANUAL = 1'b0;
  localparam logic MODO_SCAN   = 1'b1;

  localparam int MAX_CHANNELS = 16;

  // Wide one-hot enable for a channel index; callers truncate to their channel count.
  function automatic logic [MAX_CHANNELS-1:0] onehot(input logic [3:0] idx);
    logic [MAX_CHANNELS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/module_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled; fin_o flags the last cycle of a dwell.
// Shared with the display refresh logic.
module module_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fin_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign fin_o = (count == LAST);

  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr_i) begin
      count <= '0;
    end else if (en_i) begin
      count <= fin_o ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/module_mux_scan.sv
// N-channel registered multiplexer with manual select and round-robin scan.
// Build macro MUX_SCAN_BLANK_EN inserts one blanked (onehot_o=0) cycle on every channel change.
module module_mux_scan
  import mux_scan_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     modo_i,
  input  logic [SEL_W-1:0]         selec_i,
  input  logic [CHANNELS*BITS-1:0] dato_i,
  output logic [BITS-1:0]          salida_o,
  output logic [SEL_W-1:0]         canal_o,
  output logic [CHANNELS-1:0]      onehot_o,
  output logic                     valido_o
);

  state_t                state;
  logic                  fin;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [SEL_W-1:0]      canal_next;
  logic [SEL_W-1:0]      canal_wrap;
  logic [BITS-1:0]       chan_data;
  logic [CHANNELS-1:0]   oh_next;
  logic                  changed;

  // Counter only runs while actively scanning; leaving IDLE starts a fresh dwell.
  assign cnt_clr = !en_i || (modo_i == MODO_MANUAL) || (state == IDLE);
  assign cnt_en  = (modo_i == MODO_SCAN);

  module_dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .fin_o (fin)
  );

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    canal_wrap = (canal_o == SEL_W'(CHANNELS - 1)) ? '0 : canal_o + SEL_W'(1);
    canal_next = canal_o;
    if (modo_i == MODO_MANUAL) begin
      if (int'(selec_i) < CHANNELS) canal_next = selec_i;
    end else if ((state != IDLE) && fin) begin
      canal_next = canal_wrap;
    end
    changed   = (canal_next != canal_o);
    chan_data = dato_i[int'(canal_next)*BITS +: BITS];
    oh_next   = CHANNELS'(onehot(4'(canal_next)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      salida_o <= '0;
      canal_o  <= '0;
      onehot_o <= '0;
      valido_o <= 1'b0;
    end else if (!en_i) begin
      state    <= IDLE;
      onehot_o <= '0;
      valido_o <= 1'b0;
    end else begin
      salida_o <= chan_data;
      canal_o  <= canal_next;
      valido_o <= (state == IDLE) || changed;
`ifdef MUX_SCAN_BLANK_EN
      if ((state != IDLE) && changed) begin
        state    <= BLANK;
        onehot_o <= '0;
      end else begin
        state    <= SHOW;
        onehot_o <= oh_next;
      end
`else
      state    <= SHOW;
      onehot_o <= oh_next;
`endif
    end
  end

endmodule

// File: tb/tb_module_mux_scan.sv
// Directed self-checking bench for module_mux_scan (4-channel and 3-channel instances, DWELL=3).
module tb_module_mux_scan;

`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK_BUILD = 1'b1;
`else
  localparam bit BLANK_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en, modo;
  logic [1:0]  selec;
  logic [15:0] dato;
  logic [3:0]  salida;
  logic [1:0]  canal;
  logic [3:0]  onehot;
  logic        valido;

  logic        en_b, modo_b;
  logic [1:0]  selec_b;
  logic [11:0] dato_b;
  logic [3:0]  salida_b;
  logic [1:0]  canal_b;
  logic [2:0]  onehot_b;
  logic        valido_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] scan_nib [4] = '{4'h5, 4'hA, 4'h3, 4'h7};
  logic [3:0] man_nib  [3] = '{4'h5, 4'hD, 4'hA};
  int         man_sel  [3] = '{0, 3, 1};

  always #5 clk = ~clk;

  module_mux_scan #(.BITS(4), .CHANNELS(4), .DWELL(3)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .modo_i(modo), .selec_i(selec),
    .dato_i(dato), .salida_o(salida), .canal_o(canal), .onehot_o(onehot),
    .valido_o(valido)
  );

  module_mux_scan #(.BITS(4), .CHANNELS(3), .DWELL(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en_b), .modo_i(modo_b), .selec_i(selec_b),
    .dato_i(dato_b), .salida_o(salida_b), .canal_o(canal_b), .onehot_o(onehot_b),
    .valido_o(valido_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; en = 1'b0; modo = 1'b0; selec = 2'd0; dato = 16'hD3A5;
    en_b = 1'b0; modo_b = 1'b0; selec_b = 2'd0; dato_b = 12'hC96;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_a", {salida, canal, onehot, valido}, '0);
      check("reset_b", {salida_b, canal_b, onehot_b, valido_b}, '0);
    end

    // Release with manual select 2
    rst = 1'b0; en = 1'b1; modo = 1'b0; selec = 2'd2;
    tick();
    check("rel_salida", salida, 4'h3);
    check("rel_canal", canal, 2);
    check("rel_onehot", onehot, 4'b0100);
    check("rel_valido", valido, 1);
    tick();
    check("rel_valido_end", valido, 0);
    check("rel_onehot_hold", onehot, 4'b0100);

    // Manual stepping 0, 3, 1
    for (int i = 0; i < 3; i++) begin
      selec = 2'(man_sel[i]);
      tick();
      check("man_salida", salida, man_nib[i]);
      check("man_canal", canal, man_sel[i]);
      check("man_valido", valido, 1);
      check("man_onehot_first", onehot, BLANK_BUILD ? 4'b0 : (4'b0001 << man_sel[i]));
      tick();
      check("man_valido_end", valido, 0);
      check("man_onehot", onehot, 4'b0001 << man_sel[i]);
    end

    // Data change within the same channel: new data, no pulse
    selec = 2'd3;
    tick();
    check("sel3_salida", salida, 4'hD);
    tick();
    dato = 16'h73A5;
    tick();
    check("datachg_salida", salida, 4'h7);
    check("datachg_valido", valido, 0);

    // Scan from channel 0, DWELL=3
    selec = 2'd0;
    tick();
    tick();
    modo = 1'b1;
    check("scan_k0_canal", canal, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      c = (k / 3) % 4;
      check("scan_canal", canal, c);
      check("scan_salida", salida, scan_nib[c]);
      check("scan_valido", valido, (k % 3 == 0) ? 1 : 0);
      check("scan_onehot", onehot,
            (BLANK_BUILD && (k % 3 == 0)) ? 4'b0 : (4'b0001 << c));
    end

    // Disable mid-scan: onehot off, outputs held even if data moves
    tick();
    check("scan_k13_canal", canal, 0);
    en = 1'b0;
    tick();
    check("idle_onehot", onehot, 0);
    check("idle_valido", valido, 0);
    check("idle_salida", salida, 4'h5);
    dato = 16'h1111;
    tick();
    check("idle_salida_hold", salida, 4'h5);
    check("idle_canal_hold", canal, 0);
    dato = 16'h73A5;

    // Resume: same channel, fresh 3-cycle dwell
    en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      c = (r < 3) ? 0 : 1;
      check("resume_canal", canal, c);
      check("resume_valido", valido, (r == 0 || r == 3) ? 1 : 0);
      check("resume_onehot", onehot,
            (BLANK_BUILD && r == 3) ? 4'b0 : (4'b0001 << c));
    end

    // Scan -> manual at counter=1, then back to scan
    tick();
    check("sw_canal_pre", canal, 1);
    modo = 1'b0; selec = 2'd0;
    tick();
    check("sw_manual_canal", canal, 0);
    check("sw_manual_valido", valido, 1);
    modo = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("sw_scan_canal", canal, (k < 3) ? 0 : 1);
      check("sw_scan_valido", valido, (k == 3) ? 1 : 0);
    end

    // Out-of-range select on the 3-channel instance
    en_b = 1'b1; modo_b = 1'b0; selec_b = 2'd1;
    tick();
    check("oor_first_canal", canal_b, 1);
    check("oor_first_salida", salida_b, 4'h9);
    check("oor_first_valido", valido_b, 1);
    selec_b = 2'd3;
    tick();
    check("oor_canal_hold", canal_b, 1);
    check("oor_salida_hold", salida_b, 4'h9);
    check("oor_valido", valido_b, 0);
    check("oor_onehot", onehot_b, 3'b010);
    selec_b = 2'd2;
    tick();
    check("oor_ch2_canal", canal_b, 2);
    check("oor_ch2_salida", salida_b, 4'hC);

    // Asynchronous reset mid-scan, then restart at channel 0
    #2 rst = 1'b1;
    #1;
    check("async_rst", {salida, canal, onehot, valido}, '0);
    tick();
    rst = 1'b0;
    tick();
    check("restart_canal", canal, 0);
    check("restart_valido", valido, 1);
    check("restart_onehot", onehot, 4'b0001);
    tick();
    tick();
    tick();
    check("restart_advance", canal, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_mux_scan.md
Name: module_mux_scan

Overview:
- Parametrised N-channel registered multiplexer with two modes: manual channel select and automatic round-robin scan with a programmable dwell time.
- Drives shared-bus display paths, e.g. 7-segment digit multiplexing. It supplies the selected data word, the channel index, and a one-hot channel enable.
- Replaces the purely combinational 4:1 selection in the display datapath.

Parameters:
- BITS, 4: width of each data channel.
- CHANNELS, 4: number of input channels; legal range 2..16.
- DWELL, 4: clock cycles each channel is shown in scan mode; must be ≥1, or ≥2 when MUX_SCAN_BLANK_EN is defined.
- SEL_W, $clog2(CHANNELS): derived width of the channel index; not overridden.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: asynchronous reset, active-high.
- en_i, input, 1: block enable.
- modo_i, input, 1: 0 = manual, 1 = scan.
- selec_i, input, SEL_W: manual channel select.
- dato_i, input, CHANNELS*BITS: packed channels; channel k occupies bits [k*BITS +: BITS].
- salida_o, output, BITS: registered selected data.
- canal_o, output, SEL_W: registered current channel index.
- onehot_o, output, CHANNELS: channel enable, 1 << canal_o while showing.
- valido_o, output, 1: one-cycle pulse when a new channel is presented.

Behaviour:
- Reset (async assert, synchronous-safe deassert): salida_o=0, canal_o=0, onehot_o=0, valido_o=0, dwell counter=0, FSM=IDLE.
- FSM states: IDLE, SHOW, and BLANK (BLANK exists only with the macro).
- IDLE
  - Entered whenever en_i=0; checked with priority over everything else except reset.
  - onehot_o=0 and valido_o=0.
  - salida_o and canal_o hold their values; the counter clears.
  - en_i=1 moves IDLE→SHOW on the next edge, with valido_o=1 in that first SHOW cycle.
- Data path
  - At every clock edge in SHOW: salida_o <= dato_i[canal_next], canal_o <= canal_next.
  - salida_o therefore tracks changes on dato_i with 1-cycle latency even when the channel does not change.
  - salida_o and canal_o always change in the same cycle.
- Manual mode (modo_i=0)
  - canal_next = selec_i when selec_i < CHANNELS; otherwise canal_o holds.
  - Latency from selec_i to canal_o/salida_o is 1 cycle.
  - The dwell counter is held at 0.
- Scan mode (modo_i=1)
  - The dwell counter counts 0..DWELL-1.
  - When the counter reaches DWELL-1: it clears, and canal_next = canal_o+1, wrapping CHANNELS-1 → 0.
  - Each channel is shown exactly DWELL cycles; the full period is CHANNELS*DWELL cycles.
  - DWELL=1 advances every cycle.
- onehot_o = 1 << canal_o in SHOW; 0 in IDLE and BLANK.
- valido_o pulses for 1 cycle:
  - in the cycle canal_o takes a different value;
  - in the first SHOW cycle after IDLE.
  - Within the same channel, data changes do not pulse it.
- Mode switches
  - manual→scan: scanning starts from the current canal_o with the counter at 0.
  - scan→manual: takes effect on the next edge and the counter clears.
  - Toggling modo_i every cycle is legal; each cycle obeys the mode sampled at that edge.
- Simultaneous events: rst_i overrides everything. en_i=0 overrides any mode or select change in the same cycle.
- Reset mid-scan: outputs return to their reset values immediately; the scan restarts at channel 0 once en_i=1.

Optional Feature:
- Macro: MUX_SCAN_BLANK_EN.
- Defined:
  - Every channel change passes through one BLANK cycle. In that cycle salida_o, canal_o and valido_o already take their new values, and onehot_o=0.
  - The following cycle returns to SHOW with onehot_o = 1 << canal_o.
  - In scan mode BLANK consumes the first dwell cycle, so the period stays CHANNELS*DWELL.
  - In manual mode the change appears on onehot_o 2 cycles after selec_i.
- Not defined: no BLANK state; channel changes go straight from SHOW to SHOW.

Decomposition:
- Package mux_scan_pkg holds:
  - the state_t enum (IDLE, SHOW, BLANK);
  - localparams MODO_MANUAL=1'b0 and MODO_SCAN=1'b1;
  - a function onehot(idx) returning the CHANNELS-wide enable.
- One sub-module, module_dwell_counter (parameter DWELL).
  - Inputs: clk_i, rst_i, clr_i, en_i.
  - Output: fin_o, asserted when count == DWELL-1.
  - Reused by the display refresh logic.

Test Plan:
1. Reset/enable, BITS=4, CHANNELS=4. Set dato_i=16'hD3A5, hold rst_i for 3 cycles, then release with en_i=1, modo_i=0, selec_i=2. Required: all outputs 0 during reset; then salida_o=4'h3, canal_o=2, onehot_o=4'b0100, and a single-cycle valido_o pulse.
2. Manual select, same dato_i. Step selec_i through 0, 3, 1. Required:
   - 1-cycle latency on each step;
   - salida_o=5, then D, then A;
   - valido_o pulses 3 times.
   - Then set selec_i=3 and change dato_i[15:12] to 4'h7: salida_o=7 one cycle later with no valido_o pulse.
3. Scan, DWELL=3. Set modo_i=1 starting from canal_o=0. Required:
   - canal_o sequence 0,0,0,1,1,1,2,2,2,3,3,3,0;
   - onehot_o follows canal_o;
   - period 12 cycles;
   - valido_o every 3 cycles.
4. Boundaries:
   - Out-of-range select (CHANNELS=3, selec_i=3): canal_o holds its previous value.
   - en_i low mid-scan: onehot_o=0 and salida_o held.
   - en_i high again: scan resumes at the same channel with a fresh dwell of 3 cycles.
5. Mode switch: switch scan→manual at counter=1 with selec_i=0. Required: canal_o=0 next cycle. Switch back to scan: the first advance occurs exactly DWELL cycles later.
6. MUX_SCAN_BLANK_EN defined, DWELL=3, scan mode. Required:
   - each channel shows one onehot_o=0 cycle followed by 2 SHOW cycles;
   - canal_o updates in the BLANK cycle;
   - period stays 12 cycles.
